// File: rtl/wb_stage.sv
// wb_stage -- write-back stage of the five-stage RV64 pipeline.
//
// Holds one retiring instruction between the memory stage and the register
// file. Non-load results are captured on accept; loads wait for data memory,
// then the returned doubleword is shifted, truncated and sign/zero-extended.
// The register-file write port is driven from held registers during the
// single FULL cycle, and every FULL cycle bumps the retired-instruction count.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   mem_i_*                  instruction from the memory stage (valid/fields)
//   wb_o_ready               stage can accept this cycle (state-only)
//   dmem_i_rvalid/rdata      load data return (aligned doubleword)
//   write_back_o_reg_*       register-file write port
//   write_back_o_instret     retired-instruction counter
module wb_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_i_valid,
    output logic            wb_o_ready,
    input  logic            mem_i_reg_wen,
    input  logic [4:0]      mem_i_rd,
    input  logic [1:0]      mem_i_wb_sel,
    input  logic [XLEN-1:0] mem_i_alu_result,
    input  logic [XLEN-1:0] mem_i_pc_plus4,
    input  logic [XLEN-1:0] mem_i_csr_rdata,
    input  logic [1:0]      mem_i_load_size,
    input  logic            mem_i_load_unsigned,
    input  logic [2:0]      mem_i_addr_low,
    input  logic            dmem_i_rvalid,
    input  logic [XLEN-1:0] dmem_i_rdata,
    output logic            write_back_o_reg_wen,
    output logic [4:0]      write_back_o_reg_rd,
    output logic [XLEN-1:0] write_back_o_reg_data,
    output logic [63:0]     write_back_o_instret
);

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_PC4  = 2'd2;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        WAIT_LOAD = 2'd1,
        FULL      = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [4:0]      rd_q, rd_d;
    logic            reg_wen_q, reg_wen_d;
    logic [1:0]      load_size_q, load_size_d;
    logic            load_uns_q, load_uns_d;
    logic [2:0]      addr_low_q, addr_low_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [63:0]     instret_q, instret_d;

    logic            accept;
    logic [XLEN-1:0] sel_value;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_ext;

    // Ready is a pure function of state so no comb path from mem_i_valid.
    assign wb_o_ready = (state_q != WAIT_LOAD);
    assign accept     = mem_i_valid & wb_o_ready;

    always_comb begin
        sel_value = mem_i_alu_result;
        case (mem_i_wb_sel)
            SEL_ALU: sel_value = mem_i_alu_result;
            SEL_PC4: sel_value = mem_i_pc_plus4;
            default: sel_value = mem_i_csr_rdata;
        endcase
    end

    // Extraction uses the held load attributes; the data arrives later.
    assign shifted = dmem_i_rdata >> {addr_low_q, 3'b000};

    always_comb begin
        load_ext = shifted;
        case (load_size_q)
            2'd0: load_ext = {{(XLEN-8){~load_uns_q & shifted[7]}}, shifted[7:0]};
            2'd1: load_ext = {{(XLEN-16){~load_uns_q & shifted[15]}}, shifted[15:0]};
            2'd2: load_ext = {{(XLEN-32){~load_uns_q & shifted[31]}}, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        reg_wen_d   = reg_wen_q;
        load_size_d = load_size_q;
        load_uns_d  = load_uns_q;
        addr_low_d  = addr_low_q;
        data_d      = data_q;
        instret_d   = instret_q;

        if (state_q == FULL) begin
            instret_d = instret_q + 64'd1;
        end

        if (state_q == WAIT_LOAD) begin
            if (dmem_i_rvalid) begin
                data_d  = load_ext;
                state_d = FULL;
            end
        end else if (accept) begin
            rd_d        = mem_i_rd;
            reg_wen_d   = mem_i_reg_wen;
            load_size_d = mem_i_load_size;
            load_uns_d  = mem_i_load_unsigned;
            addr_low_d  = mem_i_addr_low;
            // The LOAD selection is carried by the WAIT_LOAD state itself.
            if (mem_i_wb_sel == SEL_LOAD) begin
                state_d = WAIT_LOAD;
            end else begin
                data_d  = sel_value;
                state_d = FULL;
            end
        end else if (state_q == FULL) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            rd_q        <= '0;
            reg_wen_q   <= 1'b0;
            load_size_q <= '0;
            load_uns_q  <= 1'b0;
            addr_low_q  <= '0;
            data_q      <= '0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            reg_wen_q   <= reg_wen_d;
            load_size_q <= load_size_d;
            load_uns_q  <= load_uns_d;
            addr_low_q  <= addr_low_d;
            data_q      <= data_d;
            instret_q   <= instret_d;
        end
    end

    assign write_back_o_reg_wen  = (state_q == FULL) & reg_wen_q & (rd_q != 5'd0);
    assign write_back_o_reg_rd   = (state_q == FULL) ? rd_q : 5'd0;
    assign write_back_o_reg_data = (state_q == FULL) ? data_q : '0;
    assign write_back_o_instret  = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_i_valid;
    logic        wb_o_ready;
    logic        mem_i_reg_wen;
    logic [4:0]  mem_i_rd;
    logic [1:0]  mem_i_wb_sel;
    logic [63:0] mem_i_alu_result;
    logic [63:0] mem_i_pc_plus4;
    logic [63:0] mem_i_csr_rdata;
    logic [1:0]  mem_i_load_size;
    logic        mem_i_load_unsigned;
    logic [2:0]  mem_i_addr_low;
    logic        dmem_i_rvalid;
    logic [63:0] dmem_i_rdata;
    logic        write_back_o_reg_wen;
    logic [4:0]  write_back_o_reg_rd;
    logic [63:0] write_back_o_reg_data;
    logic [63:0] write_back_o_instret;

    wb_stage #(.XLEN(64)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .mem_i_valid           (mem_i_valid),
        .wb_o_ready            (wb_o_ready),
        .mem_i_reg_wen         (mem_i_reg_wen),
        .mem_i_rd              (mem_i_rd),
        .mem_i_wb_sel          (mem_i_wb_sel),
        .mem_i_alu_result      (mem_i_alu_result),
        .mem_i_pc_plus4        (mem_i_pc_plus4),
        .mem_i_csr_rdata       (mem_i_csr_rdata),
        .mem_i_load_size       (mem_i_load_size),
        .mem_i_load_unsigned   (mem_i_load_unsigned),
        .mem_i_addr_low        (mem_i_addr_low),
        .dmem_i_rvalid         (dmem_i_rvalid),
        .dmem_i_rdata          (dmem_i_rdata),
        .write_back_o_reg_wen  (write_back_o_reg_wen),
        .write_back_o_reg_rd   (write_back_o_reg_rd),
        .write_back_o_reg_data (write_back_o_reg_data),
        .write_back_o_instret  (write_back_o_instret)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one slot that is either free, waiting on memory,
    // or holding a finished result for one cycle.
    bit              m_holding;
    bit              m_waiting;
    logic [4:0]      m_rd;
    bit              m_wen;
    int              m_size;
    bit              m_uns;
    int              m_off;
    logic [63:0]     m_data;
    longint unsigned m_count;

    function automatic logic [63:0] ref_ext(logic [63:0] dw, int size, bit uns, int off);
        int              bits;
        longint unsigned field;
        longint unsigned span;
        bits  = 8 << size;
        field = dw >> (8 * off);
        if (bits < 64) begin
            span  = 64'd1 << bits;
            field = field % span;
            if (!uns && field >= (span >> 1)) field = field - span;
        end
        return field;
    endfunction

    task automatic model_reset();
        m_holding = 0; m_waiting = 0; m_rd = 0; m_wen = 0;
        m_size = 0; m_uns = 0; m_off = 0; m_data = 0; m_count = 0;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model(string tag);
        bit full;
        full = m_holding && !m_waiting;
        chk({tag, ".ready"}, {63'd0, wb_o_ready}, {63'd0, !m_waiting});
        chk({tag, ".wen"},   {63'd0, write_back_o_reg_wen}, {63'd0, full && m_wen && m_rd != 0});
        chk({tag, ".rd"},    {59'd0, write_back_o_reg_rd}, full ? {59'd0, m_rd} : 64'd0);
        chk({tag, ".data"},  write_back_o_reg_data, full ? m_data : 64'd0);
        chk({tag, ".instret"}, write_back_o_instret, m_count);
    endtask

    // Inputs are already driven; advance the model and the DUT by one edge.
    task automatic step(string tag);
        bit full;
        full = m_holding && !m_waiting;
        if (full) m_count++;
        if (m_waiting) begin
            if (dmem_i_rvalid) begin
                m_data    = ref_ext(dmem_i_rdata, m_size, m_uns, m_off);
                m_waiting = 0;
            end
        end else if (mem_i_valid) begin
            m_holding = 1;
            m_rd = mem_i_rd; m_wen = mem_i_reg_wen;
            m_size = mem_i_load_size; m_uns = mem_i_load_unsigned; m_off = mem_i_addr_low;
            case (mem_i_wb_sel)
                2'd0: begin m_data = mem_i_alu_result; m_waiting = 0; end
                2'd1: m_waiting = 1;
                2'd2: begin m_data = mem_i_pc_plus4;   m_waiting = 0; end
                default: begin m_data = mem_i_csr_rdata; m_waiting = 0; end
            endcase
        end else if (full) begin
            m_holding = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic set_instr(bit v, bit wen, logic [4:0] rd, logic [1:0] sel,
                             logic [63:0] val, logic [1:0] size, bit uns, logic [2:0] off);
        mem_i_valid = v; mem_i_reg_wen = wen; mem_i_rd = rd; mem_i_wb_sel = sel;
        mem_i_alu_result = val; mem_i_pc_plus4 = ~val; mem_i_csr_rdata = val ^ 64'h5A5A;
        mem_i_load_size = size; mem_i_load_unsigned = uns; mem_i_addr_low = off;
    endtask

    task automatic idle();
        mem_i_valid = 0; dmem_i_rvalid = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        #1;
        model_reset();
        check_model("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    task automatic run_load(string tag, logic [1:0] size, bit uns, logic [2:0] off,
                            logic [63:0] dw, logic [63:0] exp);
        set_instr(1, 1, 5'd7, 2'd1, 64'h0, size, uns, off);
        dmem_i_rvalid = 0;
        step({tag, "_acc"});
        idle();
        dmem_i_rvalid = 1; dmem_i_rdata = dw;
        step({tag, "_ret"});
        chk({tag, "_data"}, write_back_o_reg_data, exp);
        dmem_i_rvalid = 0;
        step({tag, "_drain"});
    endtask

    initial begin
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
        dmem_i_rvalid = 0; dmem_i_rdata = 0;
        @(negedge clk);
        do_reset();
        chk("rst_ready", {63'd0, wb_o_ready}, 64'd1);
        chk("rst_instret", write_back_o_instret, 64'd0);

        // Single ALU op
        set_instr(1, 1, 5'd5, 2'd0, 64'h1234, 0, 0, 0);
        step("alu");
        chk("alu_wen", {63'd0, write_back_o_reg_wen}, 64'd1);
        chk("alu_rd", {59'd0, write_back_o_reg_rd}, 64'd5);
        chk("alu_data", write_back_o_reg_data, 64'h1234);
        idle();
        step("alu_done");
        chk("alu_instret", write_back_o_instret, 64'd1);

        // Byte and word loads, signed and unsigned
        run_load("lb",  2'd0, 0, 3'd3, 64'h00000000_80FF7F00, 64'hFFFFFFFF_FFFFFF80);
        run_load("lbu", 2'd0, 1, 3'd3, 64'h00000000_80FF7F00, 64'h80);
        run_load("lw",  2'd2, 0, 3'd4, 64'h80000001_00000000, 64'hFFFFFFFF_80000001);
        run_load("lwu", 2'd2, 1, 3'd4, 64'h80000001_00000000, 64'h80000001);
        run_load("ld",  2'd3, 1, 3'd0, 64'hF000000F_12345678, 64'hF000000F_12345678);

        // Delayed load return: stall three cycles with no write
        set_instr(1, 1, 5'd9, 2'd1, 0, 2'd2, 0, 3'd4);
        step("ldly_acc");
        idle();
        for (int i = 0; i < 3; i++) begin
            step("ldly_stall");
            chk("ldly_ready", {63'd0, wb_o_ready}, 64'd0);
            chk("ldly_wen", {63'd0, write_back_o_reg_wen}, 64'd0);
        end
        dmem_i_rvalid = 1; dmem_i_rdata = 64'h80000001_00000000;
        step("ldly_ret");
        chk("ldly_data", write_back_o_reg_data, 64'hFFFFFFFF_80000001);
        idle();
        step("ldly_drain");

        // Ten back-to-back ALU ops from a fresh reset
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_instr(1, 1, 5'(i + 1), 2'd0, 64'(i * 3 + 100), 0, 0, 0);
            step("b2b");
            chk("b2b_wen", {63'd0, write_back_o_reg_wen}, 64'd1);
            chk("b2b_ready", {63'd0, wb_o_ready}, 64'd1);
        end
        idle();
        step("b2b_done");
        chk("b2b_instret", write_back_o_instret, 64'd10);

        // rd=0, reg_wen=0, CSR and JAL
        set_instr(1, 1, 5'd0, 2'd0, 64'h77, 0, 0, 0);
        step("rd0");
        chk("rd0_wen", {63'd0, write_back_o_reg_wen}, 64'd0);
        set_instr(1, 0, 5'd3, 2'd0, 64'h78, 0, 0, 0);
        step("nowen");
        chk("nowen_wen", {63'd0, write_back_o_reg_wen}, 64'd0);
        chk("nowen_instret", write_back_o_instret, 64'd11);
        set_instr(1, 1, 5'd4, 2'd3, 64'h0, 0, 0, 0);
        mem_i_csr_rdata = 64'hABCD;
        step("csr");
        chk("csr_data", write_back_o_reg_data, 64'hABCD);
        set_instr(1, 1, 5'd1, 2'd2, 64'h0, 0, 0, 0);
        mem_i_pc_plus4 = 64'h8000_0104;
        step("jal");
        chk("jal_data", write_back_o_reg_data, 64'h8000_0104);
        idle();
        step("misc_done");
        chk("misc_instret", write_back_o_instret, 64'd14);

        // Reset while waiting for a load; late rvalid is ignored
        set_instr(1, 1, 5'd6, 2'd1, 0, 2'd3, 0, 0);
        step("rstw_acc");
        idle();
        do_reset();
        dmem_i_rvalid = 1; dmem_i_rdata = 64'hDEAD_BEEF;
        step("rstw_rvalid");
        chk("rstw_wen", {63'd0, write_back_o_reg_wen}, 64'd0);
        chk("rstw_instret", write_back_o_instret, 64'd0);
        chk("rstw_ready", {63'd0, wb_o_ready}, 64'd1);
        idle();

        // Randomized traffic checked against the model every cycle
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] sz;
            logic [2:0] off;
            sz  = 2'($urandom_range(0, 3));
            off = 3'($urandom_range(0, 7)) & ~3'((1 << sz) - 1);
            set_instr($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom),
                      2'($urandom), {$urandom, $urandom}, sz, 1'($urandom), off);
            dmem_i_rvalid = ($urandom_range(0, 2) == 0);
            dmem_i_rdata  = {$urandom, $urandom};
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the five-stage RV64 pipeline, between the memory stage and the register file.
- Holds one retiring instruction and waits for load data from the data memory when needed.
- Sign- or zero-extends load data, then selects the write-back value from the ALU result, load data, PC+4 or CSR read data.
- Drives the register-file write port and counts retired instructions.

Parameters:
XLEN, 64, datapath width in bits; only 64 is supported.

Ports:
clk  input  1  pipeline clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset.
mem_i_valid  input  1  memory stage presents an instruction.
wb_o_ready  output  1  this stage accepts an instruction this cycle.
mem_i_reg_wen  input  1  instruction writes rd.
mem_i_rd  input  5  destination register index.
mem_i_wb_sel  input  2  result source: 0 ALU, 1 LOAD, 2 PC+4, 3 CSR.
mem_i_alu_result  input  XLEN  ALU result.
mem_i_pc_plus4  input  XLEN  link value.
mem_i_csr_rdata  input  XLEN  CSR old value.
mem_i_load_size  input  2  0 byte, 1 half, 2 word, 3 double.
mem_i_load_unsigned  input  1  zero-extend (LBU/LHU/LWU).
mem_i_addr_low  input  3  byte offset of the load within the doubleword.
dmem_i_rvalid  input  1  load data valid.
dmem_i_rdata  input  XLEN  naturally aligned doubleword read from memory.
write_back_o_reg_wen  output  1  register-file write enable.
write_back_o_reg_rd  output  5  register-file write index.
write_back_o_reg_data  output  XLEN  register-file write data.
write_back_o_instret  output  64  retired-instruction count.

Behaviour:
- Reset: asynchronous, active-low.
  - State goes to EMPTY.
  - All held registers clear.
  - write_back_o_reg_wen, write_back_o_reg_rd, write_back_o_reg_data and write_back_o_instret are 0.
  - Any pending load is discarded; an rvalid arriving after reset is ignored.
- States:
  - EMPTY: no instruction held.
  - WAIT_LOAD: load accepted, data not yet returned.
  - FULL: result ready; retires this cycle.
- wb_o_ready: 1 in EMPTY and FULL, 0 in WAIT_LOAD. It depends only on state, with no combinational path from mem_i_valid.
- Accept:
  - Occurs on an edge where mem_i_valid=1 and wb_o_ready=1.
  - Captures rd, reg_wen, wb_sel, load_size, load_unsigned and addr_low.
  - If wb_sel≠LOAD: captures the selected value and goes to FULL.
  - If wb_sel=LOAD: goes to WAIT_LOAD.
- WAIT_LOAD:
  - dmem_i_rvalid is sampled only in this state; it is ignored elsewhere.
  - On rvalid=1: captures the extended load data and goes to FULL.
  - There is no timeout; the stage stalls indefinitely.
- FULL:
  - Retires exactly one cycle.
  - At the next edge: if a new accept occurs, goes to FULL or WAIT_LOAD per the new instruction; otherwise goes to EMPTY.
  - This gives back-to-back throughput of 1 instruction per cycle for non-loads.
- Write port:
  - write_back_o_reg_wen = (state==FULL) & held reg_wen & (held rd≠0).
  - rd and data are driven from the held registers; they are 0 when state≠FULL.
  - The register file commits at the edge ending the FULL cycle.
- Latency:
  - Non-load accepted at edge N: FULL during cycle N+1, register written at edge N+2.
  - Load: rvalid in cycle k gives FULL in cycle k+1.
- Load extension:
  - Field = dmem_i_rdata >> (8*addr_low), truncated to 8, 16, 32 or 64 bits.
  - Sign-extended unless load_unsigned=1.
  - Doubleword loads ignore load_unsigned.
  - Misaligned loads are trapped upstream and never reach this stage.
- Instret:
  - Increments by 1 on every edge ending a FULL cycle, whether or not rd is written (includes rd=x0, stores and branches forwarded as reg_wen=0).
  - Wraps from 2^64-1 to 0.
- Simultaneous retire and accept in the same cycle is legal and required.
- Reset asserted while in WAIT_LOAD or FULL: the instruction is lost and instret is not incremented.

Test Plan:
- ALU op, rd=5, result 0x1234 accepted at edge 1 -> in cycle 2, reg_wen=1, rd=5, data=0x1234; instret=1 after edge 2.
- Load byte at addr_low=3, rdata=0x00000000_80FF7F00, signed -> after rvalid, data=0xFFFFFFFF_FFFFFF80; same load unsigned -> 0x80.
- Load word at addr_low=4, rdata=0x80000001_00000000, signed -> 0xFFFFFFFF_80000001; LWU -> 0x80000001; rvalid delayed 3 cycles -> wb_o_ready=0 for those 3 cycles, no write.
- Ten back-to-back ALU ops with mem_i_valid held high -> ten consecutive write cycles, wb_o_ready constantly 1, instret=10.
- ALU op with rd=0, or with reg_wen=0 -> reg_wen output 0, instret still increments; CSR op with wb_sel=3, csr_rdata=0xABCD -> data=0xABCD; JAL with wb_sel=2 -> data=pc_plus4.
- Reset asserted in WAIT_LOAD, then rvalid=1 after release -> state EMPTY, no write, instret=0, wb_o_ready=1.
